// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H synchronous FIFO bus scheduler.
package ft232h_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_RX,
        GRANT_TX,
        DRAIN,
        TURN
    } sched_state_t;

    typedef enum logic {
        DIR_RX,
        DIR_TX
    } dir_t;

    localparam int BEAT_CNT_W = 16;

    // Width of a counter that must hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ft232h_bus_scheduler.sv
// Half-duplex bus-ownership scheduler for the FT232H FIFO port: round-robin on contention,
// per-direction burst quotas, and an idle turnaround gap between grants.
module ft232h_bus_scheduler
    import ft232h_pkg::*;
#(
    parameter int unsigned RX_BURST_MAX      = 64,
    parameter int unsigned TX_BURST_MAX      = 64,
    parameter int unsigned TURNAROUND_CYCLES = 2
) (
    input  logic        usb_clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        rx_ready_i,
    input  logic        receiving_i,
    input  logic        tx_ready_i,
    input  logic        sending_i,
    output logic        receive_o,
    output logic        send_o,
    output logic        busy_o,
    output logic [15:0] rx_beats_o,
    output logic [15:0] tx_beats_o
);

    localparam int unsigned BURST_MAX_ALL = (RX_BURST_MAX > TX_BURST_MAX) ? RX_BURST_MAX : TX_BURST_MAX;
    localparam int unsigned BURST_W       = cnt_width(BURST_MAX_ALL);
    localparam int unsigned TURN_W        = cnt_width(TURNAROUND_CYCLES);

    localparam logic [BURST_W-1:0] RX_QUOTA  = BURST_W'(RX_BURST_MAX);
    localparam logic [BURST_W-1:0] TX_QUOTA  = BURST_W'(TX_BURST_MAX);
    localparam logic [TURN_W-1:0]  TURN_LOAD =
        TURN_W'((TURNAROUND_CYCLES == 0) ? 0 : TURNAROUND_CYCLES - 1);

    sched_state_t          state_q, state_d;
    dir_t                  last_q, last_d;
    dir_t                  grant_dir;
    logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;
    logic                  receive_q, receive_d;
    logic                  send_q, send_d;
    logic                  busy_q, busy_d;
    logic [BEAT_CNT_W-1:0] rx_beats_q, rx_beats_d;
    logic [BEAT_CNT_W-1:0] tx_beats_q, tx_beats_d;

    logic rx_quota_full;
    logic tx_quota_full;
    logic engines_idle;

    // A zero quota means unlimited, so the count never reaches a "full" value.
    assign rx_quota_full = (RX_BURST_MAX != 0) && (burst_cnt_q == RX_QUOTA);
    assign tx_quota_full = (TX_BURST_MAX != 0) && (burst_cnt_q == TX_QUOTA);
    assign engines_idle  = !receiving_i && !sending_i;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        grant_dir   = DIR_RX;
        rx_beats_d  = rx_beats_q + BEAT_CNT_W'(receiving_i);
        tx_beats_d  = tx_beats_q + BEAT_CNT_W'(sending_i);

        case (state_q)
            IDLE: begin
                if (rx_ready_i && tx_ready_i) begin
                    grant_dir = (last_q == DIR_TX) ? DIR_RX : DIR_TX;
                end else if (tx_ready_i) begin
                    grant_dir = DIR_TX;
                end
                // Never hand out the bus while either engine still drives it.
                if (enable_i && engines_idle && (rx_ready_i || tx_ready_i)) begin
                    state_d     = (grant_dir == DIR_RX) ? GRANT_RX : GRANT_TX;
                    last_d      = grant_dir;
                    burst_cnt_d = '0;
                end
            end

            GRANT_RX: begin
                if (receiving_i && (RX_BURST_MAX != 0) && !rx_quota_full) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if ((!rx_ready_i && !receiving_i) || (rx_quota_full && tx_ready_i) || !enable_i) begin
                    state_d = DRAIN;
                end
            end

            GRANT_TX: begin
                if (sending_i && (TX_BURST_MAX != 0) && !tx_quota_full) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if ((!tx_ready_i && !sending_i) || (tx_quota_full && rx_ready_i) || !enable_i) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (engines_idle) begin
                    if (TURNAROUND_CYCLES > 0) begin
                        state_d    = TURN;
                        turn_cnt_d = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            TURN: begin
                if (turn_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next state, so a grant appears one edge after the decision.
        receive_d = (state_d == GRANT_RX);
        send_d    = (state_d == GRANT_TX);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears every flop,
    // so a reset mid-transfer drops both grants without waiting for a clock edge.
    always_ff @(posedge usb_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            last_q      <= DIR_TX;
            burst_cnt_q <= '0;
            turn_cnt_q  <= '0;
            receive_q   <= 1'b0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            rx_beats_q  <= '0;
            tx_beats_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            receive_q   <= receive_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
            rx_beats_q  <= rx_beats_d;
            tx_beats_q  <= tx_beats_d;
        end
    end

    assign receive_o  = receive_q;
    assign send_o     = send_q;
    assign busy_o     = busy_q;
    assign rx_beats_o = rx_beats_q;
    assign tx_beats_o = tx_beats_q;

endmodule
